unidad_control_segmentada: RTL and testbench
============================================

// Module: unidad_control_segmentada
// PURPOSE
//  Pipelined successor of the single-cycle opcode decoder for the segmented MIPS datapath.
//  Decodes the ID-stage opcode into WB/M/EX control bundles and carries them through
//  ID/EX, EX/MEM and MEM/WB control registers.
//  Detects load-use hazards (stall + bubble), applies branch flushes and counts stall cycles.
// PARAMETERS
//  OP_W      6   opcode width
//  ALUOP_W   3   ALUOp field width (>=3); decoded codes zero-extended
//  REG_W     5   register-index width
//  CNT_W     16  stall-counter width
//  HAZARD_EN 1   1 = load-use detection active; 0 = never stall
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          synchronous, active-high
//  op          in   OP_W       opcode of the instruction in ID
//  id_rs       in   REG_W      rs of the instruction in ID
//  id_rt       in   REG_W      rt of the instruction in ID
//  flush       in   1          branch taken (resolved in MEM); kill younger instructions
//  ex_ctrl     out  ALUOP_W+2  ID/EX reg: {ALUSrc, ALUOp, RegDst}
//  m_ctrl      out  3          EX/MEM reg: {MemToWrite, MemRead, Branch}
//  wb_ctrl     out  2          MEM/WB reg: {RegWrite, MemToReg}
//  jump_n      out  1          comb, ID stage: 0 = jump opcode decoded, else 1
//  pc_write    out  1          comb: 0 = hold PC
//  ifid_write  out  1          comb: 0 = hold IF/ID
//  illegal     out  1          comb: opcode not in decode table
//  stall_cnt   out  CNT_W      saturating count of stall cycles
// BEHAVIOUR
//  Decode (comb, {WB|M|EX-ALUOp}):
//   R 000000: 10|000|0,010,1   lw 100011: 11|010|1,000,0   sw 101011: 00|100|1,000,0
//   beq 000100: 00|001|0,001,0   addi 001000: 10|000|1,011,0   andi 001100: 10|000|1,100,0
//   ori 001101: 10|000|1,101,0   slti 001010: 10|000|1,110,0   j 000010: all 0, jump_n=0
//   any other opcode: all 0, jump_n=1, illegal=1 (no latching of previous values).
//  Hazard (comb): stall = HAZARD_EN & idex_memread & idex_rt!=0 &
//   (idex_rt==id_rs | idex_rt==id_rt); idex_memread/idex_rt = registered copies in ID/EX.
//   stall -> pc_write=0, ifid_write=0; else both 1.
//  Clock edge, priority reset > flush > stall > normal:
//   reset: ex_ctrl, m_ctrl, wb_ctrl, idex_rt, idex_memread, stall_cnt <= 0.
//   flush: ID/EX and EX/MEM control <= 0; MEM/WB <= EX/MEM (older instr completes).
//     stall suppressed: pc_write/ifid_write=1, stall_cnt does not increment.
//   stall: ID/EX <= 0 (bubble); EX/MEM <= ID/EX; MEM/WB <= EX/MEM;
//     stall_cnt += 1, saturates at all-ones.
//   normal: ID/EX <= decode(op), idex_rt <= id_rt; EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
//  Latency: decode in ID appears on ex_ctrl 1 cycle later, m_ctrl 2, wb_ctrl 3.
//  A stall lasts exactly one cycle per lw: the bubble clears idex_memread.
//  illegal instr travels as an all-zero bubble.
//  Reset mid-pipeline discards all in-flight control.
//  During reset: outputs combinationally derived from op; registers are 0.
// TESTING
//  T1 reset=1 two cycles, op=100011 -> ex/m/wb_ctrl=0, stall_cnt=0, pc_write=1.
//  T2 op=000000 then 101011 then 001010 back-to-back, no hazard
//     -> ex_ctrl 00101,10000,11100 on cycles 1,2,3; wb_ctrl 10,00,10 on cycles 3,4,5.
//  T3 lw rt=5, next R with rs=5 -> pc_write=ifid_write=0 one cycle.
//     -> ex_ctrl=0 bubble, then R decoded; stall_cnt=1.
//  T4 lw rt=0 followed by rs=0 -> no stall; HAZARD_EN=0 with rt=5 -> no stall.
//  T5 flush=1 while ID/EX=addi and EX/MEM=lw, and stall condition true
//     -> ex_ctrl=0, m_ctrl=0, wb_ctrl=11, pc_write=1, stall_cnt unchanged.
//  T6 op=111111 -> illegal=1, ex_ctrl=0 next cycle.
//     op=000010 -> jump_n=0.
//     CNT_W=2 with 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/unidad_control_segmentada.sv
// Pipelined MIPS control unit: ID decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use stall detection, branch flush and stall counter.
module unidad_control_segmentada #(
  parameter int OP_W      = 6,
  parameter int ALUOP_W   = 3,
  parameter int REG_W     = 5,
  parameter int CNT_W     = 16,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               flush,
  output logic [ALUOP_W+1:0] ex_ctrl,
  output logic [2:0]         m_ctrl,
  output logic [1:0]         wb_ctrl,
  output logic               jump_n,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               illegal,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  logic [1:0]         d_wb;
  logic [2:0]         d_m;
  logic               d_src;
  logic [2:0]         d_alu;
  logic               d_dst;
  logic [ALUOP_W+1:0] d_ex;

  logic [2:0]         idex_m;
  logic [1:0]         idex_wb;
  logic [REG_W-1:0]   idex_rt;
  logic               idex_memread;
  logic [1:0]         exmem_wb;

  logic               hazard;
  logic               stall;

  // Opcode decode; unknown opcodes yield an all-zero bundle
  always_comb begin
    d_wb    = 2'b00;
    d_m     = 3'b000;
    d_src   = 1'b0;
    d_alu   = 3'b000;
    d_dst   = 1'b0;
    jump_n  = 1'b1;
    illegal = 1'b0;
    unique case (op)
      OP_R:    begin d_wb = 2'b10; d_alu = 3'b010; d_dst = 1'b1; end
      OP_LW:   begin d_wb = 2'b11; d_m = 3'b010; d_src = 1'b1; end
      OP_SW:   begin d_m = 3'b100; d_src = 1'b1; end
      OP_BEQ:  begin d_m = 3'b001; d_alu = 3'b001; end
      OP_ADDI: begin d_wb = 2'b10; d_src = 1'b1; d_alu = 3'b011; end
      OP_ANDI: begin d_wb = 2'b10; d_src = 1'b1; d_alu = 3'b100; end
      OP_ORI:  begin d_wb = 2'b10; d_src = 1'b1; d_alu = 3'b101; end
      OP_SLTI: begin d_wb = 2'b10; d_src = 1'b1; d_alu = 3'b110; end
      OP_J:    jump_n = 1'b0;
      default: illegal = 1'b1;
    endcase
    d_ex = {d_src, ALUOP_W'(d_alu), d_dst};
  end

  // Load-use detection; a taken branch overrides the stall
  always_comb begin
    hazard = HAZARD_EN && idex_memread && (idex_rt != '0) &&
             ((idex_rt == id_rs) || (idex_rt == id_rt));
    stall      = hazard && !flush;
    pc_write   = !stall;
    ifid_write = !stall;
  end

  assign idex_memread = idex_m[1];

  // Control pipeline: reset > flush > stall > normal advance
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl   <= '0;
      idex_m    <= '0;
      idex_wb   <= '0;
      idex_rt   <= '0;
      m_ctrl    <= '0;
      exmem_wb  <= '0;
      wb_ctrl   <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      ex_ctrl  <= '0;
      idex_m   <= '0;
      idex_wb  <= '0;
      idex_rt  <= '0;
      m_ctrl   <= '0;
      exmem_wb <= '0;
      wb_ctrl  <= exmem_wb;
    end else if (stall) begin
      ex_ctrl  <= '0;
      idex_m   <= '0;
      idex_wb  <= '0;
      idex_rt  <= '0;
      m_ctrl   <= idex_m;
      exmem_wb <= idex_wb;
      wb_ctrl  <= exmem_wb;
      if (stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      ex_ctrl  <= d_ex;
      idex_m   <= d_m;
      idex_wb  <= d_wb;
      idex_rt  <= id_rt;
      m_ctrl   <= idex_m;
      exmem_wb <= idex_wb;
      wb_ctrl  <= exmem_wb;
    end
  end

endmodule

// File: tb/tb_unidad_control_segmentada.sv
// Bench for unidad_control_segmentada: main instance, hazard-disabled
// instance and 2-bit counter instance driven by a common stimulus.
module tb_unidad_control_segmentada;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       flush = 1'b0;

  logic [4:0]  ex_ctrl, nh_ex, c2_ex;
  logic [2:0]  m_ctrl, nh_m, c2_m;
  logic [1:0]  wb_ctrl, nh_wb, c2_wb;
  logic        jump_n, nh_jn, c2_jn;
  logic        pc_write, nh_pcw, c2_pcw;
  logic        ifid_write, nh_ifw, c2_ifw;
  logic        illegal, nh_ill, c2_ill;
  logic [15:0] stall_cnt, nh_cnt;
  logic [1:0]  c2_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unidad_control_segmentada u_dut (
    .clk(clk), .reset(reset), .op(op), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .ex_ctrl(ex_ctrl), .m_ctrl(m_ctrl), .wb_ctrl(wb_ctrl),
    .jump_n(jump_n), .pc_write(pc_write), .ifid_write(ifid_write),
    .illegal(illegal), .stall_cnt(stall_cnt));

  unidad_control_segmentada #(.HAZARD_EN(1'b0)) u_nh (
    .clk(clk), .reset(reset), .op(op), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .ex_ctrl(nh_ex), .m_ctrl(nh_m), .wb_ctrl(nh_wb),
    .jump_n(nh_jn), .pc_write(nh_pcw), .ifid_write(nh_ifw),
    .illegal(nh_ill), .stall_cnt(nh_cnt));

  unidad_control_segmentada #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .op(op), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .ex_ctrl(c2_ex), .m_ctrl(c2_m), .wb_ctrl(c2_wb),
    .jump_n(c2_jn), .pc_write(c2_pcw), .ifid_write(c2_ifw),
    .illegal(c2_ill), .stall_cnt(c2_cnt));

  typedef struct packed {
    logic [4:0]  ex;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];

  // reference pipeline state
  logic [4:0]  s_ex = '0;
  logic [2:0]  s_idm = '0, s_exm = '0;
  logic [1:0]  s_idwb = '0, s_exwb = '0, s_wb = '0;
  logic [4:0]  s_idrt = '0;
  logic [15:0] s_cnt = '0;
  logic [1:0]  s_cnt2 = '0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010;
  localparam logic [5:0] BEQ = 6'b000100, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, J = 6'b000010, BAD = 6'b111111;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {wb[1:0], m[2:0], ALUSrc, ALUOp[2:0], RegDst}
  function automatic logic [9:0] dec(input logic [5:0] o);
    case (o)
      6'b000000: dec = 10'b10_000_0_010_1;
      6'b100011: dec = 10'b11_010_1_000_0;
      6'b101011: dec = 10'b00_100_1_000_0;
      6'b000100: dec = 10'b00_001_0_001_0;
      6'b001000: dec = 10'b10_000_1_011_0;
      6'b001100: dec = 10'b10_000_1_100_0;
      6'b001101: dec = 10'b10_000_1_101_0;
      6'b001010: dec = 10'b10_000_1_110_0;
      default:   dec = 10'b0;
    endcase
  endfunction

  function automatic logic legal(input logic [5:0] o);
    legal = (o == R) || (o == LW) || (o == SW) || (o == BEQ) ||
            (o == ADDI) || (o == ANDI) || (o == ORI) ||
            (o == SLTI) || (o == J);
  endfunction

  task automatic step(input logic rst, input logic [5:0] o,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic fl);
    logic  hz, st;
    logic [9:0] d;
    exp_t  e;
    @(negedge clk);
    reset = rst; op = o; id_rs = rs; id_rt = rt; flush = fl;
    #1;
    hz = s_idm[1] && (s_idrt != 0) && (s_idrt == rs || s_idrt == rt);
    st = hz && !fl;
    check("pc_write", pc_write, !st);
    check("ifid_write", ifid_write, !st);
    check("illegal", illegal, !legal(o));
    check("jump_n", jump_n, o != J);
    check("nh_pc_write", nh_pcw, 1'b1);
    d = dec(o);
    if (rst) begin
      s_ex = 0; s_idm = 0; s_idwb = 0; s_idrt = 0;
      s_exm = 0; s_exwb = 0; s_wb = 0; s_cnt = 0; s_cnt2 = 0;
    end else if (fl) begin
      s_wb = s_exwb; s_exm = 0; s_exwb = 0;
      s_ex = 0; s_idm = 0; s_idwb = 0; s_idrt = 0;
    end else if (st) begin
      s_wb = s_exwb; s_exm = s_idm; s_exwb = s_idwb;
      s_ex = 0; s_idm = 0; s_idwb = 0; s_idrt = 0;
      if (s_cnt != 16'hFFFF) s_cnt = s_cnt + 1;
      if (s_cnt2 != 2'b11) s_cnt2 = s_cnt2 + 1;
    end else begin
      s_wb = s_exwb; s_exm = s_idm; s_exwb = s_idwb;
      s_ex = d[4:0]; s_idm = d[7:5]; s_idwb = d[9:8]; s_idrt = rt;
    end
    e.ex = s_ex; e.m = s_exm; e.wb = s_wb; e.cnt = s_cnt; e.cnt2 = s_cnt2;
    sb.push_back(e);
  endtask

  // compare registered outputs just after each active edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ex_ctrl", ex_ctrl, e.ex);
      check("m_ctrl", m_ctrl, e.m);
      check("wb_ctrl", wb_ctrl, e.wb);
      check("stall_cnt", stall_cnt, e.cnt);
      check("c2_stall_cnt", c2_cnt, e.cnt2);
      check("nh_stall_cnt", nh_cnt, 16'd0);
    end
  end

  initial begin
    // reset with lw in ID
    step(1, LW, 1, 5, 0);
    step(1, LW, 1, 5, 0);
    // R, sw, slti back-to-back, then drain
    step(0, R, 1, 2, 0);
    step(0, SW, 3, 4, 0);
    step(0, SLTI, 6, 7, 0);
    step(0, ADDI, 8, 9, 0);
    step(0, ADDI, 8, 9, 0);
    step(0, ADDI, 8, 9, 0);
    // load-use: lw rt=5, then R rs=5 stalls once
    step(0, LW, 1, 5, 0);
    step(0, R, 5, 6, 0);
    step(0, R, 5, 6, 0);
    step(0, ADDI, 0, 0, 0);
    // lw rt=0 never stalls
    step(0, LW, 1, 0, 0);
    step(0, R, 0, 0, 0);
    // rt match on id_rt side
    step(0, LW, 2, 9, 0);
    step(0, ANDI, 3, 9, 0);
    step(0, ANDI, 3, 9, 0);
    // flush with addi in ID/EX and lw in EX/MEM
    step(0, LW, 1, 7, 0);
    step(0, ADDI, 1, 2, 0);
    step(0, R, 7, 7, 1);
    step(0, ORI, 1, 2, 0);
    // flush while a load-use hazard is present
    step(0, LW, 1, 3, 0);
    step(0, R, 3, 4, 1);
    step(0, BEQ, 3, 4, 0);
    // illegal and jump opcodes
    step(0, BAD, 1, 2, 0);
    step(0, J, 1, 2, 0);
    step(0, ADDI, 1, 2, 0);
    // repeated stalls saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      step(0, LW, 1, 4, 0);
      step(0, R, 4, 1, 0);
      step(0, R, 4, 1, 0);
    end
    // reset mid-pipeline discards in-flight control
    step(0, LW, 1, 2, 0);
    step(0, SW, 3, 4, 0);
    step(1, R, 1, 2, 0);
    step(0, R, 1, 2, 0);
    step(0, ADDI, 1, 2, 0);
    @(posedge clk);
    #3;
    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
